// File: rtl/counter_pkg.sv
// counter_pkg: boundary-mode constants and load clamping shared by the counter blocks
package counter_pkg;
  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT = 1;
  // Clamp a requested load value to the top of the count range
  function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max);
    return val > max ? max : val;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides enabled cycles down to a one-cycle count tick
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] cnt;
  assign tick = en && cnt == PW'(PRESCALE - 1);
  // Advance only on enabled cycles, restarting the period on tick, clear or load
  always_ff @(posedge clk) begin
    if (reset || sync_clr || tick) cnt <= '0;
    else if (en) cnt <= cnt + PW'(1);
  end
endmodule

// File: rtl/param_counter.sv
// param_counter: prescaled up/down counter with load, clear, wrap/saturate, tc and sticky ovf
module param_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX_VAL = 255,
  parameter int PRESCALE = 1,
  parameter int SAT_MODE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam bit SAT = SAT_MODE == CNT_SAT;
  logic tick;
  logic bnd;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] load_c;
  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk(clk),
    .reset(reset),
    .en(en),
    .sync_clr(clear | load),
    .tick(tick)
  );
  assign load_c = WIDTH'(clamp_load(32'(load_val), 32'(MAX_VAL)));
  // Next count for a tick; boundary compares stay within WIDTH bits
  always_comb begin
    bnd = up_dn ? counter == MAXV : counter == '0;
    nxt = up_dn ? (bnd ? (SAT ? MAXV : '0) : counter + WIDTH'(1))
                : (bnd ? (SAT ? '0 : MAXV) : counter - WIDTH'(1));
  end
  // Counter, terminal-count pulse and sticky overflow with reset > clear > load > tick
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      counter <= '0;
      tc <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      counter <= load_c;
      tc <= 1'b0;
    end else if (tick) begin
      counter <= nxt;
      tc <= bnd;
      ovf <= ovf | bnd;
    end else tc <= 1'b0;
  end
endmodule

// File: tb/tb_param_counter.sv
// tb_param_counter: directed checks of param_counter across several parameter sets
module tb_param_counter;
  logic clk = 1'b0;
  logic reset;
  logic en[5], up[5], ld[5], clr[5], tc[5], ovf[5];
  logic [7:0] lv[5], cnt[5];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  param_counter u0 (.clk(clk), .reset(reset), .en(en[0]), .up_dn(up[0]), .load(ld[0]), .load_val(lv[0]), .clear(clr[0]), .counter(cnt[0]), .tc(tc[0]), .ovf(ovf[0]));
  param_counter #(.MAX_VAL(9)) u1 (.clk(clk), .reset(reset), .en(en[1]), .up_dn(up[1]), .load(ld[1]), .load_val(lv[1]), .clear(clr[1]), .counter(cnt[1]), .tc(tc[1]), .ovf(ovf[1]));
  param_counter #(.MAX_VAL(9), .SAT_MODE(1)) u2 (.clk(clk), .reset(reset), .en(en[2]), .up_dn(up[2]), .load(ld[2]), .load_val(lv[2]), .clear(clr[2]), .counter(cnt[2]), .tc(tc[2]), .ovf(ovf[2]));
  param_counter #(.PRESCALE(4)) u3 (.clk(clk), .reset(reset), .en(en[3]), .up_dn(up[3]), .load(ld[3]), .load_val(lv[3]), .clear(clr[3]), .counter(cnt[3]), .tc(tc[3]), .ovf(ovf[3]));
  param_counter #(.MAX_VAL(99)) u4 (.clk(clk), .reset(reset), .en(en[4]), .up_dn(up[4]), .load(ld[4]), .load_val(lv[4]), .clear(clr[4]), .counter(cnt[4]), .tc(tc[4]), .ovf(ovf[4]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 5; i++) begin
      en[i] = 0; up[i] = 1; ld[i] = 0; clr[i] = 0; lv[i] = 0;
    end
    reset = 1;
    cyc();
    cyc();
    chk("rst_cnt", 32'(cnt[0]), 0);
    chk("rst_tc", 32'(tc[0]), 0);
    chk("rst_ovf", 32'(ovf[0]), 0);
    reset = 0;
    en[0] = 1;
    for (int i = 1; i <= 255; i++) begin
      cyc();
      chk("t1_cnt", 32'(cnt[0]), 32'(i));
      chk("t1_tc", 32'(tc[0]), 0);
    end
    cyc();
    chk("t1_wrap", 32'(cnt[0]), 0);
    chk("t1_wrap_tc", 32'(tc[0]), 1);
    chk("t1_ovf", 32'(ovf[0]), 1);
    cyc();
    chk("t1_after", 32'(cnt[0]), 1);
    chk("t1_tc_once", 32'(tc[0]), 0);
    for (int i = 0; i < 4; i++) cyc();
    chk("t6_pre_cnt", 32'(cnt[0]), 5);
    chk("t6_pre_ovf", 32'(ovf[0]), 1);
    reset = 1;
    cyc();
    reset = 0;
    chk("t6_cnt", 32'(cnt[0]), 0);
    chk("t6_tc", 32'(tc[0]), 0);
    chk("t6_ovf", 32'(ovf[0]), 0);
    cyc();
    chk("t6_resume", 32'(cnt[0]), 1);
    en[0] = 0;
    en[1] = 1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("t2_cnt", 32'(cnt[1]), 32'(i % 10));
      chk("t2_tc", 32'(tc[1]), (i % 10 == 0) ? 1 : 0);
    end
    chk("t2_ovf", 32'(ovf[1]), 1);
    en[1] = 0;
    en[2] = 1;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      chk("t3_up_cnt", 32'(cnt[2]), i < 9 ? 32'(i) : 9);
      chk("t3_up_tc", 32'(tc[2]), i >= 10 ? 1 : 0);
    end
    up[2] = 0;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      chk("t3_dn_cnt", 32'(cnt[2]), j < 9 ? 32'(9 - j) : 0);
      chk("t3_dn_tc", 32'(tc[2]), j >= 10 ? 1 : 0);
    end
    en[2] = 0;
    cyc();
    chk("t3_tc_idle", 32'(tc[2]), 0);
    en[3] = 1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("t4_cnt", 32'(cnt[3]), 32'(k / 4));
    end
    en[3] = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t4_hold", 32'(cnt[3]), 2);
    end
    en[3] = 1;
    cyc();
    chk("t4_delayed", 32'(cnt[3]), 2);
    cyc();
    chk("t4_step", 32'(cnt[3]), 3);
    en[3] = 0;
    en[4] = 1;
    up[4] = 0;
    cyc();
    chk("t5_dn_wrap", 32'(cnt[4]), 99);
    chk("t5_dn_tc", 32'(tc[4]), 1);
    chk("t5_ovf_set", 32'(ovf[4]), 1);
    en[4] = 0;
    ld[4] = 1;
    lv[4] = 200;
    cyc();
    chk("t5_clamp", 32'(cnt[4]), 99);
    chk("t5_ld_ovf", 32'(ovf[4]), 1);
    chk("t5_ld_tc", 32'(tc[4]), 0);
    lv[4] = 50;
    en[4] = 1;
    up[4] = 1;
    cyc();
    chk("t5_ld_tick", 32'(cnt[4]), 50);
    ld[4] = 0;
    cyc();
    chk("t5_count", 32'(cnt[4]), 51);
    clr[4] = 1;
    cyc();
    chk("t5_clr_cnt", 32'(cnt[4]), 0);
    chk("t5_clr_ovf", 32'(ovf[4]), 0);
    clr[4] = 0;
    en[4] = 0;
    cyc();
    chk("t5_idle", 32'(cnt[4]), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
